// File: rtl/hazard_control_unit.sv
// Pipeline sequencer for the 5-stage RV32 core: PC/IF-ID hold, flush and bubble control,
// memory freeze with deferred branch flush, freeze timeout and saturating hazard counters.
module hazard_control_unit #(
  parameter int unsigned COUNT_W     = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4:0]         id_rs1_addr,
  input  logic [4:0]         id_rs2_addr,
  input  logic               id_uses_rs1,
  input  logic               id_uses_rs2,
  input  logic               ex_mem_read,
  input  logic [4:0]         ex_rd_addr,
  input  logic               ex_branch_taken,
  input  logic               mem_req,
  input  logic               mem_ready,
  input  logic               perf_clear,
  output logic               pc_write_en,
  output logic               if_id_write_en,
  output logic               if_id_flush,
  output logic               id_ex_bubble,
  output logic               pipe_freeze,
  output logic               mem_timeout_err,
  output logic [COUNT_W-1:0] stall_count,
  output logic [COUNT_W-1:0] freeze_count,
  output logic [COUNT_W-1:0] flush_count
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

  typedef enum logic {
    ST_RUN,
    ST_FREEZE
  } state_e;

  // Which pipeline action wins this cycle, in priority order
  typedef enum logic [1:0] {
    ACT_RUN,
    ACT_FREEZE,
    ACT_FLUSH,
    ACT_STALL
  } act_e;

  state_e              state_q;
  state_e              state_d;
  act_e                act_c;
  logic                flush_pending_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic                timeout_err_q;
  logic [COUNT_W-1:0]  stall_cnt_q;
  logic [COUNT_W-1:0]  freeze_cnt_q;
  logic [COUNT_W-1:0]  flush_cnt_q;

  logic mem_busy_c;
  logic rs1_hit_c;
  logic rs2_hit_c;
  logic load_use_c;
  logic flush_now_c;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + COUNT_W'(1);
  endfunction

  // Hazard terms
  always_comb begin
    mem_busy_c  = mem_req & ~mem_ready;
    rs1_hit_c   = id_uses_rs1 & (id_rs1_addr == ex_rd_addr);
    rs2_hit_c   = id_uses_rs2 & (id_rs2_addr == ex_rd_addr);
    load_use_c  = ex_mem_read & (ex_rd_addr != 5'd0) & (rs1_hit_c | rs2_hit_c);
    flush_now_c = ex_branch_taken | flush_pending_q;
  end

  // Action select: memory freeze beats flush, flush kills a load-use victim
  always_comb begin
    act_c = ACT_RUN;
    if (mem_busy_c) begin
      act_c = ACT_FREEZE;
    end else if (flush_now_c) begin
      act_c = ACT_FLUSH;
    end else if (load_use_c) begin
      act_c = ACT_STALL;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:    if (mem_busy_c)  state_d = ST_FREEZE;
      ST_FREEZE: if (!mem_busy_c) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // Zero-latency control outputs; reset forces a killed, held front end
  always_comb begin
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    pipe_freeze    = 1'b0;
    if (!rst_n) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      if_id_flush    = 1'b1;
      id_ex_bubble   = 1'b1;
    end else begin
      unique case (act_c)
        ACT_FREEZE: begin
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          pipe_freeze    = 1'b1;
        end
        ACT_FLUSH: begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end
        ACT_STALL: begin
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          id_ex_bubble   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A branch resolved during a freeze is remembered until it can be applied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pending_q <= 1'b0;
    end else if (act_c == ACT_FLUSH) begin
      flush_pending_q <= 1'b0;
    end else if (ex_branch_taken && mem_busy_c) begin
      flush_pending_q <= 1'b1;
    end
  end

  // Freeze watchdog; the error is sticky but never breaks the freeze
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (!mem_busy_c) begin
        wait_cnt_q <= '0;
      end else if (wait_cnt_q != WAIT_MAX) begin
        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      end
      if (mem_busy_c && (wait_cnt_q == WAIT_MAX)) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  // Saturating performance counters; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      freeze_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else if (perf_clear) begin
      stall_cnt_q  <= '0;
      freeze_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (act_c == ACT_STALL)  stall_cnt_q  <= sat_inc(stall_cnt_q);
      if (act_c == ACT_FREEZE) freeze_cnt_q <= sat_inc(freeze_cnt_q);
      if (act_c == ACT_FLUSH)  flush_cnt_q  <= sat_inc(flush_cnt_q);
    end
  end

  assign mem_timeout_err = timeout_err_q;
  assign stall_count     = stall_cnt_q;
  assign freeze_count    = freeze_cnt_q;
  assign flush_count     = flush_cnt_q;

endmodule
